// File: rtl/pifo_pkg.sv
// Shared types for the PIFO ingress path: default field widths, entry layout, buffer FSM states.
package pifo_pkg;
  localparam int PIFO_RANK_WIDTH = 10;
  localparam int PIFO_META_WIDTH = 20;

  typedef struct packed {
    logic [PIFO_RANK_WIDTH-1:0] rank;
    logic [PIFO_META_WIDTH-1:0] meta;
  } pifo_entry_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} enq_state_t;
endpackage

// File: rtl/pifo_enq_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
module pifo_enq_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 30
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [DEPTH-1:0][W-1:0] mem;

  // Contents are don't-care after reset; occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pifo_enq_buffer.sv
// Ingress staging FIFO ahead of the PIFO; issues inserts only when the PIFO is idle and not full.
// Optional statistics counters enabled by defining PIFO_ENQ_STATS_EN.
module pifo_enq_buffer
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = PIFO_RANK_WIDTH,
  parameter int META_WIDTH = PIFO_META_WIDTH,
  parameter int L2_DEPTH   = 3,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RANK_WIDTH-1:0] in_rank,
  input  logic [META_WIDTH-1:0] in_meta,
  input  logic                  flush,
  output logic                  pifo_insert,
  output logic [RANK_WIDTH-1:0] pifo_rank,
  output logic [META_WIDTH-1:0] pifo_meta,
  input  logic                  pifo_busy,
  input  logic                  pifo_full,
  output logic [L2_DEPTH:0]     occupancy,
  output logic [CNT_WIDTH-1:0]  enq_cnt,
  output logic [CNT_WIDTH-1:0]  ins_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);
  localparam int DEPTH = 1 << L2_DEPTH;
  localparam int W     = RANK_WIDTH + META_WIDTH;
  localparam logic [L2_DEPTH:0] FULL_CNT = (L2_DEPTH+1)'(DEPTH);

  enq_state_t          state;
  logic [L2_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [L2_DEPTH:0]   count, count_nxt;
  logic [W-1:0]        head;
  logic                push, pop;

  // Ready and insert are held low during reset so nothing is handed over that reset discards.
  assign in_ready    = ~rst & (state == RUN) & (count != FULL_CNT);
  assign pifo_insert = ~rst & (state == RUN) & (count != '0) & ~pifo_busy & ~pifo_full;
  assign push        = in_valid & in_ready;
  assign pop         = pifo_insert;
  assign occupancy   = count;

  pifo_enq_fifo_mem #(.DEPTH(DEPTH), .AW(L2_DEPTH), .W(W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_rank, in_meta}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign {pifo_rank, pifo_meta} = (count != '0) ? head : '0;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (pop)  rd_ptr <= rd_ptr + 1'b1;
          count <= count_nxt;
          if (flush) state <= FLUSH;
        end
        FLUSH: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
          state  <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIFO_ENQ_STATS_EN
  logic [CNT_WIDTH-1:0] enq_q, ins_q, drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      enq_q  <= '0;
      ins_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push) enq_q <= enq_q + 1'b1;
      if (pop)  ins_q <= ins_q + 1'b1;
      // count in the FLUSH cycle already reflects any push/pop of the flush-request cycle
      if (state == FLUSH) drop_q <= drop_q + CNT_WIDTH'(count);
    end
  end

  assign enq_cnt  = enq_q;
  assign ins_cnt  = ins_q;
  assign drop_cnt = drop_q;
`else
  assign enq_cnt  = '0;
  assign ins_cnt  = '0;
  assign drop_cnt = '0;
`endif
endmodule

// File: doc/pifo_enq_buffer.md
Name: pifo_enq_buffer

Overview:
Ingress staging buffer directly upstream of the PIFO top. It accepts (rank, meta) enqueue requests on a valid/ready handshake and holds them in a small circular FIFO. It issues one-cycle insert strobes to the PIFO only when the PIFO reports neither busy nor full. It absorbs bursts that arrive while the skip lists are mid-operation, and supports a flush that discards all buffered entries.

Parameters:
RANK_WIDTH, 10, rank field width; must match the PIFO.
META_WIDTH, 20, metadata field width; must match the PIFO.
L2_DEPTH, 3, log2 of buffer depth (DEPTH = 2**L2_DEPTH entries).
CNT_WIDTH, 32, width of the statistics counters.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  upstream request valid
in_ready  output  1  buffer can accept a request this cycle
in_rank  input  RANK_WIDTH  request rank
in_meta  input  META_WIDTH  request metadata
flush  input  1  single-cycle pulse; discard all buffered entries
pifo_insert  output  1  insert strobe to PIFO
pifo_rank  output  RANK_WIDTH  head-entry rank to PIFO
pifo_meta  output  META_WIDTH  head-entry metadata to PIFO
pifo_busy  input  1  PIFO busy (combinational from PIFO)
pifo_full  input  1  PIFO full
occupancy  output  L2_DEPTH+1  number of buffered entries
enq_cnt  output  CNT_WIDTH  accepted requests (stats)
ins_cnt  output  CNT_WIDTH  PIFO inserts issued (stats)
drop_cnt  output  CNT_WIDTH  entries discarded by flush (stats)

Behaviour:
- Storage: DEPTH-entry array of {rank, meta}; wr_ptr and rd_ptr are L2_DEPTH bits wide and wrap modulo DEPTH; count is L2_DEPTH+1 bits; occupancy = count.
- Reset: wr_ptr=0, rd_ptr=0, count=0, state=RUN, all counters=0.
  - Outputs after reset: in_ready=1, pifo_insert=0, occupancy=0.
  - Array contents are don't-care.
  - Reset mid-burst discards all entries; no insert is issued in the reset cycle.
- FSM states:
  - RUN: normal operation.
  - FLUSH: lasts exactly one cycle.
- RUN transitions:
  - flush=1 in RUN -> FLUSH next cycle.
  - A push or pop in that same cycle still completes.
- FLUSH cycle:
  - in_ready=0, pifo_insert=0.
  - At the end of the cycle: wr_ptr=rd_ptr=0, count=0, drop_cnt += count.
  - Next state is RUN; flush is ignored while in FLUSH.
- in_ready = (state==RUN) & (count != DEPTH). It does not depend on a same-cycle pop, so there is no combinational ready-from-PIFO path.
- Push: in_valid & in_ready writes the entry at wr_ptr, then wr_ptr++ and enq_cnt++.
- First-word fall-through: pifo_rank/pifo_meta always present the array entry at rd_ptr. They are zero when count==0.
- Pop:
  - pifo_insert = (state==RUN) & (count!=0) & ~pifo_busy & ~pifo_full, combinational.
  - On pifo_insert: rd_ptr++ and ins_cnt++.
- Latency: an entry pushed in cycle t is at the head and eligible for insert in cycle t+1 at the earliest. There is no bypass.
- Simultaneous push and pop: count unchanged; both pointers advance.
- count==1 with pop and push: the new entry becomes the head next cycle, with no bubble beyond the 1-cycle latency.
- pifo_full=1 or pifo_busy=1: entries are held indefinitely and ordering is preserved (strict FIFO order into the PIFO).
- Counters wrap modulo 2**CNT_WIDTH.

Optional Feature:
PIFO_ENQ_STATS_EN
- Defined: enq_cnt, ins_cnt and drop_cnt are implemented as described.
- Undefined: no counter registers are built; the three ports are tied to 0. All other behaviour is identical.

Decomposition:
- Shared package pifo_pkg:
  - Default RANK_WIDTH/META_WIDTH constants.
  - typedef pifo_entry_t (struct {rank, meta}).
  - FSM state enum {RUN, FLUSH}.
- One sub-module, pifo_enq_fifo_mem:
  - Parameterised DEPTH x entry register array.
  - One write port; one asynchronous read port addressed by rd_ptr.
- Pointers, count, FSM and counters stay in pifo_enq_buffer.

Test Plan:
- After reset, push rank=5 meta=0x00A1 with busy=0, full=0 -> pifo_insert=1 the following cycle with pifo_rank=5, pifo_meta=0x00A1; occupancy 1->0; enq_cnt=ins_cnt=1.
- Hold pifo_busy=1, push 8 entries (ranks 7,6,...,0) -> in_ready=0 after the 8th, occupancy=8. Release busy -> 8 inserts in order 7..0 on consecutive cycles; in_ready=1 one cycle after the first pop.
- With count=3, push and pop in the same cycle for 10 cycles -> occupancy stays 3; pointers wrap past 7; output order matches input order.
- Toggle pifo_full each cycle with 4 entries buffered -> inserts only in cycles with full=0; no entry lost or duplicated.
- Buffer 5 entries, pulse flush while push and pop are both active -> in the FLUSH cycle in_ready=0 and pifo_insert=0; occupancy=0 afterwards; drop_cnt=5 (5+1-1). Next push is accepted normally.
- Assert rst with 6 entries buffered and busy=0 -> no pifo_insert in the reset cycle; occupancy=0, counters 0, in_ready=1 on the next cycle.
